// File: rtl/beta_lsu_gen.sv
// Load/store unit for the beta execute stage. One FSM runs loads and stores one at a time over
// separate read and write ports, with lane alignment, load extension, fault capture and a timeout.
module beta_lsu_gen #(
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned AddressWidth  = 32,
    parameter int unsigned TimeoutCycles = 256
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [DataWidth-1:0]    op_data_i,
    input  logic [AddressWidth-1:0] op_addr_i,
    input  logic [11:0]             lsu_offset_i,
    input  logic                    lsu_op_en_i,
    input  logic                    lsu_op_i,
    input  logic [1:0]              lsu_op_size_i,
    input  logic                    lsu_op_unsigned_i,
    output logic                    rdata_req_o,
    output logic [AddressWidth-1:0] rdata_addr_o,
    output logic [DataWidth/8-1:0]  rdata_strb_o,
    input  logic                    rdata_ready_i,
    input  logic                    rdata_valid_i,
    input  logic                    rdata_err_i,
    input  logic [DataWidth-1:0]    rdata_data_i,
    output logic                    wdata_req_o,
    output logic [AddressWidth-1:0] wdata_addr_o,
    output logic [DataWidth/8-1:0]  wdata_strb_o,
    output logic [DataWidth-1:0]    wdata_data_o,
    input  logic                    wdata_ready_i,
    input  logic                    wdata_valid_i,
    input  logic                    wdata_err_i,
    output logic                    lsu_busy_o,
    output logic                    lsu_done_o,
    output logic [DataWidth-1:0]    lsu_result_o,
    output logic                    lsu_exc_o,
    output logic [1:0]              lsu_exc_cause_o,
    output logic [AddressWidth-1:0] lsu_exc_addr_o
);

    localparam int unsigned NB        = DataWidth / 8;
    localparam int unsigned LaneW     = $clog2(NB);
    localparam bit          HasDouble = (DataWidth == 64);
    localparam int unsigned CntW      = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [CntW-1:0] TimeoutLast =
        CntW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);

    localparam logic [1:0] CauseMisaligned = 2'b00;
    localparam logic [1:0] CauseBusErr     = 2'b01;
    localparam logic [1:0] CauseTimeout    = 2'b10;
    localparam logic [1:0] CauseIllegal    = 2'b11;

    typedef enum logic [1:0] {StIdle, StWrdy, StWvld} state_e;

    state_e                  state_q;
    logic                    op_q;
    logic [1:0]              size_q;
    logic                    uns_q;
    logic [LaneW-1:0]        lane_q;
    logic [AddressWidth-1:0] ea_q;
    logic [CntW-1:0]         cnt_q;

    logic [AddressWidth-1:0] ea;
    logic [AddressWidth-1:0] bus_addr;
    logic [LaneW-1:0]        lane;
    logic                    illegal;
    logic                    misaligned;
    logic [NB-1:0]           size_mask;
    logic [NB-1:0]           strb_new;
    logic [DataWidth-1:0]    wdata_new;

    always_comb begin
        ea        = op_addr_i + {{(AddressWidth-12){lsu_offset_i[11]}}, lsu_offset_i};
        lane      = ea[LaneW-1:0];
        bus_addr  = {ea[AddressWidth-1:LaneW], {LaneW{1'b0}}};
        illegal   = (lsu_op_size_i == 2'b11) && !HasDouble;
        case (lsu_op_size_i)
            2'b00:   begin misaligned = 1'b0;            size_mask = NB'(1);      end
            2'b01:   begin misaligned = ea[0];           size_mask = NB'(2'b11);  end
            2'b10:   begin misaligned = (ea[1:0] != 0);  size_mask = NB'(4'hF);   end
            default: begin misaligned = (ea[2:0] != 0);  size_mask = '1;          end
        endcase
        strb_new  = size_mask << lane;
        wdata_new = op_data_i << {lane, 3'b000};
    end

    logic [DataWidth-1:0] shifted;
    logic [DataWidth-1:0] ext_mask;
    logic                 sign_bit;
    logic [DataWidth-1:0] load_ext;

    always_comb begin
        shifted = rdata_data_i >> {lane_q, 3'b000};
        case (size_q)
            2'b00:   begin ext_mask = DataWidth'(8'hFF);         sign_bit = shifted[7];  end
            2'b01:   begin ext_mask = DataWidth'(16'hFFFF);      sign_bit = shifted[15]; end
            2'b10:   begin ext_mask = DataWidth'(32'hFFFF_FFFF); sign_bit = shifted[31]; end
            default: begin ext_mask = '1;  sign_bit = shifted[DataWidth-1]; end
        endcase
        load_ext = (shifted & ext_mask) | ({DataWidth{sign_bit & ~uns_q}} & ~ext_mask);
    end

    logic sel_ready;
    logic sel_valid;
    logic sel_err;
    logic timeout_hit;

    // Only the port belonging to the op in flight is listened to.
    always_comb begin
        sel_ready   = op_q ? wdata_ready_i : rdata_ready_i;
        sel_valid   = op_q ? wdata_valid_i : rdata_valid_i;
        sel_err     = op_q ? wdata_err_i   : rdata_err_i;
        timeout_hit = (TimeoutCycles != 0) && (cnt_q == TimeoutLast);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= StIdle;
            op_q            <= 1'b0;
            size_q          <= 2'b00;
            uns_q           <= 1'b0;
            lane_q          <= '0;
            ea_q            <= '0;
            cnt_q           <= '0;
            rdata_req_o     <= 1'b0;
            rdata_addr_o    <= '0;
            rdata_strb_o    <= '0;
            wdata_req_o     <= 1'b0;
            wdata_addr_o    <= '0;
            wdata_strb_o    <= '0;
            wdata_data_o    <= '0;
            lsu_busy_o      <= 1'b0;
            lsu_done_o      <= 1'b0;
            lsu_result_o    <= '0;
            lsu_exc_o       <= 1'b0;
            lsu_exc_cause_o <= 2'b00;
            lsu_exc_addr_o  <= '0;
        end else begin
            lsu_done_o <= 1'b0;
            lsu_exc_o  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (lsu_op_en_i) begin
                        if (illegal || misaligned) begin
                            lsu_done_o      <= 1'b1;
                            lsu_exc_o       <= 1'b1;
                            lsu_exc_cause_o <= illegal ? CauseIllegal : CauseMisaligned;
                            lsu_exc_addr_o  <= ea;
                        end else begin
                            op_q       <= lsu_op_i;
                            size_q     <= lsu_op_size_i;
                            uns_q      <= lsu_op_unsigned_i;
                            lane_q     <= lane;
                            ea_q       <= ea;
                            cnt_q      <= '0;
                            lsu_busy_o <= 1'b1;
                            state_q    <= StWrdy;
                            if (lsu_op_i) begin
                                wdata_req_o  <= 1'b1;
                                wdata_addr_o <= bus_addr;
                                wdata_strb_o <= strb_new;
                                wdata_data_o <= wdata_new;
                            end else begin
                                rdata_req_o  <= 1'b1;
                                rdata_addr_o <= bus_addr;
                                rdata_strb_o <= strb_new;
                            end
                        end
                    end
                end
                StWrdy, StWvld: begin
                    cnt_q <= cnt_q + CntW'(1);
                    // Ready+valid together in WRDY completes the access directly.
                    if (sel_valid && (state_q == StWvld || sel_ready)) begin
                        state_q     <= StIdle;
                        rdata_req_o <= 1'b0;
                        wdata_req_o <= 1'b0;
                        lsu_busy_o  <= 1'b0;
                        lsu_done_o  <= 1'b1;
                        if (sel_err) begin
                            lsu_exc_o       <= 1'b1;
                            lsu_exc_cause_o <= CauseBusErr;
                            lsu_exc_addr_o  <= ea_q;
                        end else begin
                            lsu_result_o <= op_q ? '0 : load_ext;
                        end
                    end else if (timeout_hit) begin
                        state_q         <= StIdle;
                        rdata_req_o     <= 1'b0;
                        wdata_req_o     <= 1'b0;
                        lsu_busy_o      <= 1'b0;
                        lsu_done_o      <= 1'b1;
                        lsu_exc_o       <= 1'b1;
                        lsu_exc_cause_o <= CauseTimeout;
                        lsu_exc_addr_o  <= ea_q;
                    end else if (state_q == StWrdy && sel_ready) begin
                        rdata_req_o <= 1'b0;
                        wdata_req_o <= 1'b0;
                        state_q     <= StWvld;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_beta_lsu_gen.sv
// Bench for beta_lsu_gen: a 32-bit and a 64-bit instance exercised one at a time, each op checked
// against a byte-level model of address, lane, extension and fault rules.
module tb_beta_lsu_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;  // 0 = 32-bit instance, 1 = 64-bit instance
    logic [63:0] op_data, rdata;
    logic [31:0] op_addr;
    logic [11:0] offset;
    logic        op_en, op_st, op_uns;
    logic [1:0]  op_size;
    logic        rrdy, rvld, rerr, wrdy, wvld, werr;

    logic        r_req32, w_req32, busy32, done32, exc32;
    logic [31:0] r_addr32, w_addr32, w_data32, res32, eaddr32;
    logic [3:0]  r_strb32, w_strb32;
    logic [1:0]  cause32;
    logic        r_req64, w_req64, busy64, done64, exc64;
    logic [31:0] r_addr64, w_addr64, eaddr64;
    logic [63:0] w_data64, res64;
    logic [7:0]  r_strb64, w_strb64;
    logic [1:0]  cause64;

    logic        o_rreq, o_wreq, o_busy, o_done, o_exc;
    logic [31:0] o_raddr, o_waddr, o_eaddr;
    logic [7:0]  o_rstrb, o_wstrb;
    logic [63:0] o_wdata, o_result;
    logic [1:0]  o_cause;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] exp_result [2];
    logic [31:0] exp_eaddr  [2];

    always #5 clk = ~clk;

    beta_lsu_gen #(.DataWidth(32), .AddressWidth(32), .TimeoutCycles(16)) u_dut32 (
        .clk_i(clk), .rst_i(rst), .op_data_i(op_data[31:0]), .op_addr_i(op_addr),
        .lsu_offset_i(offset), .lsu_op_en_i(op_en & ~sel), .lsu_op_i(op_st),
        .lsu_op_size_i(op_size), .lsu_op_unsigned_i(op_uns),
        .rdata_req_o(r_req32), .rdata_addr_o(r_addr32), .rdata_strb_o(r_strb32),
        .rdata_ready_i(rrdy & ~sel), .rdata_valid_i(rvld & ~sel), .rdata_err_i(rerr),
        .rdata_data_i(rdata[31:0]),
        .wdata_req_o(w_req32), .wdata_addr_o(w_addr32), .wdata_strb_o(w_strb32),
        .wdata_data_o(w_data32), .wdata_ready_i(wrdy & ~sel), .wdata_valid_i(wvld & ~sel),
        .wdata_err_i(werr), .lsu_busy_o(busy32), .lsu_done_o(done32), .lsu_result_o(res32),
        .lsu_exc_o(exc32), .lsu_exc_cause_o(cause32), .lsu_exc_addr_o(eaddr32)
    );

    beta_lsu_gen #(.DataWidth(64), .AddressWidth(32), .TimeoutCycles(16)) u_dut64 (
        .clk_i(clk), .rst_i(rst), .op_data_i(op_data), .op_addr_i(op_addr),
        .lsu_offset_i(offset), .lsu_op_en_i(op_en & sel), .lsu_op_i(op_st),
        .lsu_op_size_i(op_size), .lsu_op_unsigned_i(op_uns),
        .rdata_req_o(r_req64), .rdata_addr_o(r_addr64), .rdata_strb_o(r_strb64),
        .rdata_ready_i(rrdy & sel), .rdata_valid_i(rvld & sel), .rdata_err_i(rerr),
        .rdata_data_i(rdata),
        .wdata_req_o(w_req64), .wdata_addr_o(w_addr64), .wdata_strb_o(w_strb64),
        .wdata_data_o(w_data64), .wdata_ready_i(wrdy & sel), .wdata_valid_i(wvld & sel),
        .wdata_err_i(werr), .lsu_busy_o(busy64), .lsu_done_o(done64), .lsu_result_o(res64),
        .lsu_exc_o(exc64), .lsu_exc_cause_o(cause64), .lsu_exc_addr_o(eaddr64)
    );

    assign o_rreq   = sel ? r_req64  : r_req32;
    assign o_wreq   = sel ? w_req64  : w_req32;
    assign o_raddr  = sel ? r_addr64 : r_addr32;
    assign o_waddr  = sel ? w_addr64 : w_addr32;
    assign o_rstrb  = sel ? r_strb64 : {4'b0, r_strb32};
    assign o_wstrb  = sel ? w_strb64 : {4'b0, w_strb32};
    assign o_wdata  = sel ? w_data64 : {32'b0, w_data32};
    assign o_busy   = sel ? busy64   : busy32;
    assign o_done   = sel ? done64   : done32;
    assign o_result = sel ? res64    : {32'b0, res32};
    assign o_exc    = sel ? exc64    : exc32;
    assign o_cause  = sel ? cause64  : cause32;
    assign o_eaddr  = sel ? eaddr64  : eaddr32;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_state();
        check_val("rst_req",    {62'b0, o_rreq, o_wreq}, 0);
        check_val("rst_raddr",  o_raddr, 0);
        check_val("rst_waddr",  o_waddr, 0);
        check_val("rst_strb",   {o_rstrb, o_wstrb}, 0);
        check_val("rst_wdata",  o_wdata, 0);
        check_val("rst_busy",   o_busy, 0);
        check_val("rst_done",   o_done, 0);
        check_val("rst_result", o_result, 0);
        check_val("rst_exc",    {o_exc, o_cause}, 0);
        check_val("rst_eaddr",  o_eaddr, 0);
        exp_result[0] = '0; exp_result[1] = '0;
        exp_eaddr[0]  = '0; exp_eaddr[1]  = '0;
    endtask

    // Load result straight from the byte rules: pick the bytes, then widen.
    function automatic logic [63:0] load_model(input logic [63:0] rd, input int lane,
                                               input int bytes, input bit uns,
                                               input logic [63:0] dmask);
        logic [63:0] v;
        logic [63:0] m;
        int          nbits;
        nbits = 8 * bytes;
        v = (rd & dmask) >> (8 * lane);
        m = (nbits == 64) ? '1 : ((64'd1 << nbits) - 64'd1);
        v = v & m;
        if (!uns && v[nbits-1]) v = v | ~m;
        return v & dmask;
    endfunction

    task automatic set_hs(input bit st, input bit rdy, input bit vld);
        if (st) begin wrdy = rdy; wvld = vld; end
        else    begin rrdy = rdy; rvld = vld; end
    endtask

    // mode: 0 normal, 1 ready+valid together, 2 never ready (timeout), 3 reset while in WVLD.
    // Called and returns at a negedge; the op is accepted on the following posedge.
    task automatic do_op(input bit st, input logic [1:0] size, input bit uns,
                         input logic [31:0] addr, input logic [11:0] off,
                         input logic [63:0] data, input logic [63:0] rd, input bit err,
                         input int mode, input int lr, input int lv);
        int          s, nb, lane, bytes;
        logic [31:0] ea, baddr;
        logic [63:0] dmask, strb, wd;
        bit          illegal, mis;
        s       = int'(sel);
        nb      = sel ? 8 : 4;
        ea      = addr + {{20{off[11]}}, off};
        lane    = int'(ea) & (nb - 1);
        bytes   = 1 << size;
        illegal = (size == 2'b11) && !sel;
        mis     = (int'(ea) % bytes) != 0;
        baddr   = ea & ~32'(nb - 1);
        dmask   = sel ? '1 : 64'hFFFF_FFFF;
        strb    = ((64'd1 << bytes) - 64'd1) << lane;
        wd      = (data << (8 * lane)) & dmask;

        op_en = 1'b1; op_st = st; op_size = size; op_uns = uns;
        op_addr = addr; offset = off; op_data = data;
        @(negedge clk);
        op_en = 1'b0;
        if (illegal || mis) begin
            check_val("flt_done",  o_done, 1);
            check_val("flt_exc",   o_exc, 1);
            check_val("flt_cause", o_cause, illegal ? 2'b11 : 2'b00);
            check_val("flt_eaddr", o_eaddr, ea);
            check_val("flt_busy",  o_busy, 0);
            check_val("flt_noreq", {o_rreq, o_wreq}, 0);
            check_val("flt_res",   o_result, exp_result[s]);
            exp_eaddr[s] = ea;
            return;
        end
        check_val("acc_done", o_done, 0);
        check_val("acc_busy", o_busy, 1);
        check_val("acc_rreq", o_rreq, !st);
        check_val("acc_wreq", o_wreq, st);
        if (st) begin
            check_val("acc_waddr", o_waddr, baddr);
            check_val("acc_wstrb", o_wstrb, strb);
            check_val("acc_wdata", o_wdata, wd);
        end else begin
            check_val("acc_raddr", o_raddr, baddr);
            check_val("acc_rstrb", o_rstrb, strb);
        end

        if (mode == 2) begin
            repeat (15) begin
                @(negedge clk);
                check_val("to_req", st ? o_wreq : o_rreq, 1);
            end
            @(negedge clk);
            check_val("to_req_drop", {o_rreq, o_wreq}, 0);
            check_val("to_done",     o_done, 1);
            check_val("to_exc",      o_exc, 1);
            check_val("to_cause",    o_cause, 2'b10);
            check_val("to_busy",     o_busy, 0);
            check_val("to_eaddr",    o_eaddr, ea);
            exp_eaddr[s] = ea;
            @(negedge clk);
            check_val("to_done_pulse", o_done, 0);
            @(negedge clk);
            set_hs(st, 1'b0, 1'b1); rdata = rd; rerr = 1'b0; werr = 1'b0;
            @(negedge clk);
            set_hs(st, 1'b0, 1'b0);
            check_val("late_vld_done", o_done, 0);
            check_val("late_vld_busy", o_busy, 0);
            @(negedge clk);
            check_val("late_vld_done2", o_done, 0);
            check_val("late_vld_res",   o_result, exp_result[s]);
            return;
        end

        repeat (lr) begin
            @(negedge clk);
            check_val("wrdy_req",  st ? o_wreq : o_rreq, 1);
            check_val("wrdy_addr", st ? o_waddr : o_raddr, baddr);
        end
        set_hs(st, 1'b1, mode == 1);
        rdata = rd; rerr = err; werr = err;
        @(negedge clk);
        set_hs(st, 1'b0, 1'b0);
        if (mode != 1) begin
            check_val("wvld_req",  {o_rreq, o_wreq}, 0);
            check_val("wvld_busy", o_busy, 1);
            check_val("wvld_done", o_done, 0);
            if (mode == 3) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check_reset_state();
                set_hs(st, 1'b0, 1'b1); rdata = rd; rerr = 1'b0; werr = 1'b0;
                @(negedge clk);
                set_hs(st, 1'b0, 1'b0);
                check_val("postrst_done", o_done, 0);
                check_val("postrst_busy", o_busy, 0);
                @(negedge clk);
                check_val("postrst_done2", o_done, 0);
                check_val("postrst_res",   o_result, 0);
                return;
            end
            repeat (lv) begin
                @(negedge clk);
                check_val("wait_done", o_done, 0);
            end
            set_hs(st, 1'b0, 1'b1);
            rdata = rd; rerr = err; werr = err;
            @(negedge clk);
            set_hs(st, 1'b0, 1'b0);
        end
        if (err) begin
            exp_eaddr[s] = ea;
        end else begin
            exp_result[s] = st ? 64'd0 : load_model(rd, lane, bytes, uns, dmask);
        end
        check_val("cpl_done",   o_done, 1);
        check_val("cpl_busy",   o_busy, 0);
        check_val("cpl_req",    {o_rreq, o_wreq}, 0);
        check_val("cpl_exc",    o_exc, err);
        if (err) check_val("cpl_cause", o_cause, 2'b01);
        check_val("cpl_result", o_result, exp_result[s]);
        check_val("cpl_eaddr",  o_eaddr, exp_eaddr[s]);
    endtask

    task automatic run_random(input int n);
        logic [31:0] a, ea;
        logic [11:0] o;
        logic [1:0]  sz;
        int          bytes, md, mode;
        for (int i = 0; i < n; i++) begin
            sz = 2'($urandom_range(0, sel ? 3 : 2));
            if (!sel && $urandom_range(0, 15) == 0) sz = 2'b11;
            bytes = 1 << sz;
            a = $urandom;
            o = 12'($urandom);
            if ($urandom_range(0, 5) != 0) begin
                ea = a + {{20{o[11]}}, o};
                a  = a - (ea & 32'(bytes - 1));
            end
            md   = $urandom_range(0, 19);
            mode = (md == 0) ? 2 : (md < 5) ? 1 : (md == 5) ? 3 : 0;
            do_op(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, o,
                  {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 6) == 0,
                  mode, $urandom_range(0, 3), $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                check_val("idle_done", o_done, 0);
            end
        end
    endtask

    initial begin
        rst = 1'b1; sel = 1'b0;
        op_en = 1'b0; op_st = 1'b0; op_size = 2'b00; op_uns = 1'b0;
        op_addr = '0; offset = '0; op_data = '0; rdata = '0;
        rrdy = 1'b0; rvld = 1'b0; rerr = 1'b0; wrdy = 1'b0; wvld = 1'b0; werr = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_state();
        rst = 1'b0;
        @(negedge clk);

        // 32-bit instance: directed cases.
        do_op(0, 2'b00, 0, 32'h1000, 12'h003, 64'h0, 64'h8011_2233, 0, 0, 1, 1);
        check_val("tp1_signed", o_result, 64'hFFFF_FF80);
        do_op(0, 2'b00, 1, 32'h1000, 12'h003, 64'h0, 64'h8011_2233, 0, 0, 0, 2);
        check_val("tp1_unsigned", o_result, 64'h80);
        do_op(1, 2'b01, 0, 32'h2000, 12'h002, 64'hBEEF, 64'h0, 0, 0, 2, 1);
        do_op(0, 2'b10, 0, 32'h3004, 12'hFFC, 64'h0, 64'hCAFE_F00D, 0, 0, 0, 0);
        check_val("tp3_word", o_result, 64'hCAFE_F00D);
        do_op(0, 2'b10, 0, 32'h3000, 12'hFFE, 64'h0, 64'h0, 0, 0, 0, 0);
        check_val("tp3_mis_addr", o_eaddr, 32'h2FFE);
        do_op(1, 2'b10, 0, 32'h4000, 12'h000, 64'h1234_5678, 64'h0, 0, 2, 0, 0);
        do_op(0, 2'b10, 0, 32'h5000, 12'h010, 64'h0, 64'h1111_2222, 1, 1, 1, 0);
        do_op(0, 2'b01, 1, 32'h5000, 12'h012, 64'h0, 64'h9876_5432, 0, 1, 0, 0);
        do_op(0, 2'b10, 0, 32'h6000, 12'h000, 64'h0, 64'h5555_AAAA, 0, 3, 1, 0);
        do_op(0, 2'b11, 0, 32'h7000, 12'h000, 64'h0, 64'h0, 0, 0, 0, 0);
        run_random(150);

        // 64-bit instance.
        sel = 1'b1;
        do_op(0, 2'b11, 0, 32'h0, 12'h008, 64'h0, 64'h8123_4567_89AB_CDEF, 0, 0, 1, 1);
        check_val("tp6_double", o_result, 64'h8123_4567_89AB_CDEF);
        do_op(1, 2'b10, 0, 32'h100, 12'h004, 64'hDEAD_BEEF, 64'h0, 0, 0, 0, 1);
        do_op(0, 2'b01, 0, 32'h100, 12'h006, 64'h0, 64'hF00D_0000_0000_0000, 0, 0, 2, 0);
        run_random(150);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/beta_lsu_gen.md
Name: beta_lsu_gen

Overview:
Parametrised load/store unit for the beta execute stage, replacing the fixed 32-bit LSU. A single FSM serialises loads and stores over separate read and write data-memory ports. It adds effective-address generation for both loads and stores, byte-lane alignment of strobes and data, signed/unsigned load extension, misalignment/illegal-size detection, bus-error capture and a request timeout. Results and exceptions go back to the execute control unit with a one-cycle done pulse.

Parameters:
DataWidth, 32, data bus width in bits; legal values 32 or 64. NB = DataWidth/8.
AddressWidth, 32, byte-address width.
TimeoutCycles, 256, maximum cycles spent in WRDY+WVLD before abort; 0 disables the timeout.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
op_data_i  in  DataWidth  store data, right-aligned
op_addr_i  in  AddressWidth  base address
lsu_offset_i  in  12  signed offset, applied to loads and stores
lsu_op_en_i  in  1  operation request
lsu_op_i  in  1  0=load, 1=store
lsu_op_size_i  in  2  00 byte, 01 half, 10 word, 11 double (legal only when DataWidth=64)
lsu_op_unsigned_i  in  1  load zero-extends when 1, sign-extends when 0
rdata_req_o  out  1  read request
rdata_addr_o  out  AddressWidth  NB-aligned read address
rdata_strb_o  out  NB  read byte lanes
rdata_ready_i  in  1  read request accepted
rdata_valid_i  in  1  read data valid (one cycle)
rdata_err_i  in  1  read error, qualified by rdata_valid_i
rdata_data_i  in  DataWidth  read data
wdata_req_o  out  1  write request
wdata_addr_o  out  AddressWidth  NB-aligned write address
wdata_strb_o  out  NB  write byte lanes
wdata_data_o  out  DataWidth  lane-shifted write data
wdata_ready_i  in  1  write request accepted
wdata_valid_i  in  1  write complete (one cycle)
wdata_err_i  in  1  write error, qualified by wdata_valid_i
lsu_busy_o  out  1  operation in flight
lsu_done_o  out  1  one-cycle completion pulse
lsu_result_o  out  DataWidth  extended load result
lsu_exc_o  out  1  exception, valid only with lsu_done_o
lsu_exc_cause_o  out  2  00 misaligned, 01 bus error, 10 timeout, 11 illegal size
lsu_exc_addr_o  out  AddressWidth  faulting effective address

Behaviour:
- Reset: every output is 0, state is IDLE, timeout counter is 0. Reset mid-operation abandons the access. Memory responses arriving after reset are ignored.
- States: IDLE, WRDY, WVLD.
- Effective address: ea = op_addr_i + sign_extend(lsu_offset_i), computed modulo 2^AddressWidth. lane = ea[log2(NB)-1:0]. Bus address = ea with the lane bits cleared.
- Accept: the op is accepted in IDLE when lsu_op_en_i=1. lsu_op_en_i is ignored while busy.
- Illegal size or misaligned ea (ea not a multiple of the access size):
  - No memory request is issued.
  - Next cycle: lsu_done_o=1, lsu_exc_o=1, cause 11 or 00, lsu_exc_addr_o=ea, busy stays 0, state stays IDLE.
  - Illegal size takes priority over misalignment.
- Legal op, accept cycle N:
  - At N+1: the selected port has req=1, addr/strb (and data for stores) registered, busy=1, state=WRDY.
  - strb = size mask (1/3/F/FF) shifted left by lane.
  - Store data = op_data_i shifted left by 8*lane.
- WRDY: addr/strb/data are held stable while req=1. When ready_i is sampled high, req drops the next cycle and the state moves to WVLD. If ready_i and valid_i are both high in the same cycle, the access completes directly (treated as WVLD completion).
- WVLD: when valid_i is sampled high in cycle M, then at M+1: busy=0, done=1, state=IDLE.
  - Load: lsu_result_o = (rdata_data_i >> 8*lane), truncated to size, then sign- or zero-extended.
  - Store: lsu_result_o = 0.
  - err_i=1: exc=1, cause 01, exc_addr=ea, lsu_result_o unchanged.
- A new op may be accepted in the same cycle that done is asserted.
- Timeout: the counter runs in WRDY/WVLD. When it reaches TimeoutCycles, the access aborts on the next cycle: req=0, busy=0, done=1, exc=1, cause 10, state=IDLE. A late valid_i is then ignored.
- lsu_result_o and lsu_exc_addr_o hold their values until overwritten. lsu_exc_cause_o is meaningful only when lsu_exc_o=1.
- Only one port's req is ever high at a time. A ready_i or valid_i on the idle port is ignored.

Test Plan:
1. DataWidth=32, signed byte load, op_addr 0x1000, offset 0x003, rdata_data 0x80112233 -> rdata_addr 0x1000, strb 1000, result 0xFFFFFF80; same with unsigned=1 -> 0x00000080.
2. Half store, op_data 0x0000BEEF, op_addr 0x2000, offset 0x002 -> wdata_addr 0x2000, strb 1100, wdata 0xBEEF0000; after valid, done=1, busy=0.
3. Word load, op_addr 0x3004, offset 0xFFC -> ea 0x3000, strb 1111. Word load, op_addr 0x3000, offset 0xFFE -> no req, done+exc, cause 00, exc_addr 0x2FFE one cycle after accept.
4. TimeoutCycles=16, word store, ready_i held 0 -> req high 16 cycles then low, done+exc cause 10. A valid_i 3 cycles later produces no done.
5. ready_i and valid_i high together in WRDY with rdata_err_i=1 -> next cycle done, exc cause 01, result unchanged. Back-to-back op accepted on the done cycle issues req the following cycle.
6. rst_i asserted in WVLD, then valid_i pulsed -> all outputs 0, no done. size=11 with DataWidth=32 -> exc cause 11. DataWidth=64 double load at ea 0x8 -> strb 0xFF, full 64-bit result.
